wb_stage: RTL and testbench

Write-back stage of the pipelined core, and the write side of the register file whose read ports the decode stage drives. It holds the MEM/WB pipeline register, aligns and extends load data, and selects the ALU result or the load result. It then drives the register-file write port (`reg_write`, `rd_address`, `write_data`) and counts retired instructions. Optionally, it forwards the value being written to the decode-stage read ports in the same cycle.

---
 rtl/wb_stage.sv | 132 +++++++++++++
 tb/tb_wb_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// wb_stage : MEM/WB register, load align/extend, register-file write port and
//            retire counter. Optional same-cycle decode bypass: WB_BYPASS_EN.
// Revision  : 1.0
// ============================================================================
module wb_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             mem_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_reg_write,
    input  logic             mem_mem_to_reg,
    input  logic [2:0]       mem_funct3,
    input  logic [4:0]       mem_rd,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [63:0]      mem_read_data,
    output logic             rf_reg_write,
    output logic [4:0]       rf_rd_address,
    output logic [XLEN-1:0]  rf_write_data,
    output logic             wb_valid,
    output logic [CNT_W-1:0] retired_count
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]       id_rs1_address,
    input  logic [4:0]       id_rs2_address,
    input  logic [XLEN-1:0]  id_rs1_raw,
    input  logic [XLEN-1:0]  id_rs2_raw,
    output logic [XLEN-1:0]  id_rs1_data,
    output logic [XLEN-1:0]  id_rs2_data
`endif
);

    logic             valid_q,      valid_d;
    logic             reg_write_q,  reg_write_d;
    logic             mem_to_reg_q, mem_to_reg_d;
    logic [2:0]       funct3_q,     funct3_d;
    logic [4:0]       rd_q,         rd_d;
    logic [XLEN-1:0]  alu_result_q, alu_result_d;
    logic [63:0]      read_data_q,  read_data_d;
    logic [CNT_W-1:0] count_q,      count_d;

    // Count on departure: the instruction leaves on a normal advance or a flush.
    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        alu_result_d = alu_result_q;
        read_data_d  = read_data_q;
        count_d      = count_q;
        if (valid_q && (!stall || flush)) begin
            count_d = count_q + CNT_W'(1);
        end
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d      = mem_valid;
            reg_write_d  = mem_reg_write;
            mem_to_reg_d = mem_mem_to_reg;
            funct3_d     = mem_funct3;
            rd_d         = mem_rd;
            alu_result_d = mem_alu_result;
            read_data_d  = mem_read_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            funct3_q     <= 3'd0;
            rd_q         <= 5'd0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            count_q      <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            funct3_q     <= funct3_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            count_q      <= count_d;
        end
    end

    // Lane selection drops offset bits below the access size (misalignment ignored).
    logic [2:0]  off;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_w;
    logic [63:0] load_ext;

    assign off  = alu_result_q[2:0];
    assign ld_b = read_data_q[{off, 3'b000} +: 8];
    assign ld_h = read_data_q[{off[2:1], 4'b0000} +: 16];
    assign ld_w = read_data_q[{off[2], 5'b00000} +: 32];

    always_comb begin
        load_ext = read_data_q;
        case (funct3_q)
            3'b000:  load_ext = {{56{ld_b[7]}}, ld_b};
            3'b001:  load_ext = {{48{ld_h[15]}}, ld_h};
            3'b010:  load_ext = {{32{ld_w[31]}}, ld_w};
            3'b100:  load_ext = {56'd0, ld_b};
            3'b101:  load_ext = {48'd0, ld_h};
            3'b110:  load_ext = {32'd0, ld_w};
            default: load_ext = read_data_q;
        endcase
    end

    assign rf_write_data = mem_to_reg_q ? load_ext[XLEN-1:0] : alu_result_q;
    assign rf_reg_write  = valid_q & reg_write_q & (rd_q != 5'd0);
    assign rf_rd_address = rd_q;
    assign wb_valid      = valid_q;
    assign retired_count = count_q;

`ifdef WB_BYPASS_EN
    assign id_rs1_data = (rf_reg_write && (id_rs1_address == rf_rd_address)) ? rf_write_data : id_rs1_raw;
    assign id_rs2_data = (rf_reg_write && (id_rs2_address == rf_rd_address)) ? rf_write_data : id_rs2_raw;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// tb_wb_stage : table-driven load vectors, hand sequences and randomized
//               stimulus against an arithmetic reference model of wb_stage.
// Revision    : 1.0
// ============================================================================
module tb_wb_stage;
    localparam int XLEN  = 64;
    localparam int CNT_W = 64;

    logic             clock;
    logic             reset_n;
    logic             mem_valid, stall, flush, mem_reg_write, mem_mem_to_reg;
    logic [2:0]       mem_funct3;
    logic [4:0]       mem_rd;
    logic [XLEN-1:0]  mem_alu_result;
    logic [63:0]      mem_read_data;
    logic             rf_reg_write;
    logic [4:0]       rf_rd_address;
    logic [XLEN-1:0]  rf_write_data;
    logic             wb_valid;
    logic [CNT_W-1:0] retired_count;
    logic [4:0]       id_rs1_address, id_rs2_address;
    logic [XLEN-1:0]  id_rs1_raw, id_rs2_raw, id_rs1_data, id_rs2_data;

    wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .mem_valid      (mem_valid),
        .stall          (stall),
        .flush          (flush),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_to_reg (mem_mem_to_reg),
        .mem_funct3     (mem_funct3),
        .mem_rd         (mem_rd),
        .mem_alu_result (mem_alu_result),
        .mem_read_data  (mem_read_data),
        .rf_reg_write   (rf_reg_write),
        .rf_rd_address  (rf_rd_address),
        .rf_write_data  (rf_write_data),
        .wb_valid       (wb_valid),
        .retired_count  (retired_count)
`ifdef WB_BYPASS_EN
        ,
        .id_rs1_address (id_rs1_address),
        .id_rs2_address (id_rs2_address),
        .id_rs1_raw     (id_rs1_raw),
        .id_rs2_raw     (id_rs2_raw),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp;
    int n_fail;

    // Reference model state: the instruction currently sitting in write-back.
    logic        m_valid, m_rw, m_m2r;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd;
    logic [63:0] m_alu, m_rdata, m_cnt;

    typedef struct {
        logic [2:0]  f3;
        logic [2:0]  off;
        logic [63:0] exp;
    } ld_vec_t;

    ld_vec_t vecs[13];
    localparam logic [63:0] LD_DATA = 64'h8877_6655_4433_2281;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] off,
                                             input logic [63:0] d);
        int          size;
        int          base;
        logic [63:0] v;
        logic [63:0] mask;
        size = 1 << f3[1:0];
        if (size == 8) return d;
        base = (int'(off) / size) * size;
        mask = (64'd1 << (8 * size)) - 64'd1;
        v    = (d >> (8 * base)) & mask;
        if (!f3[2] && v[8*size-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_m2r = 0; m_f3 = 0; m_rd = 0;
        m_alu = 0; m_rdata = 0; m_cnt = 0;
    endtask

    task automatic check_outputs();
        logic        exp_we;
        logic [63:0] exp_wd;
        exp_we = m_valid && m_rw && (m_rd != 0);
        exp_wd = m_m2r ? ref_load(m_f3, m_alu[2:0], m_rdata) : m_alu;
        check("wb_valid", wb_valid, m_valid);
        check("rf_reg_write", rf_reg_write, exp_we);
        check("retired_count", retired_count, m_cnt);
        if (m_valid) begin
            check("rf_rd_address", rf_rd_address, m_rd);
            check("rf_write_data", rf_write_data, exp_wd);
        end
`ifdef WB_BYPASS_EN
        check("id_rs1_data", id_rs1_data,
              (exp_we && id_rs1_address == m_rd) ? exp_wd : id_rs1_raw);
        check("id_rs2_data", id_rs2_data,
              (exp_we && id_rs2_address == m_rd) ? exp_wd : id_rs2_raw);
`endif
    endtask

    // One clock: snapshot inputs, advance the model at the edge, compare after it.
    task automatic step();
        logic        s_v, s_st, s_fl, s_rw, s_m2r;
        logic [2:0]  s_f3;
        logic [4:0]  s_rd;
        logic [63:0] s_alu, s_rdata;
        s_v = mem_valid; s_st = stall; s_fl = flush; s_rw = mem_reg_write;
        s_m2r = mem_mem_to_reg; s_f3 = mem_funct3; s_rd = mem_rd;
        s_alu = mem_alu_result; s_rdata = mem_read_data;
        @(posedge clock);
        #1;
        if (m_valid && (!s_st || s_fl)) m_cnt = m_cnt + 64'd1;
        if (s_fl) begin
            m_valid = 0;
        end else if (!s_st) begin
            m_valid = s_v; m_rw = s_rw; m_m2r = s_m2r; m_f3 = s_f3;
            m_rd = s_rd; m_alu = s_alu; m_rdata = s_rdata;
        end
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] rdata);
        mem_valid = v; mem_reg_write = rw; mem_mem_to_reg = m2r; mem_funct3 = f3;
        mem_rd = rd; mem_alu_result = alu; mem_read_data = rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] saved_cnt;
        n_cmp = 0; n_fail = 0;
        clock = 0; reset_n = 0; stall = 0; flush = 0;
        drive(0, 0, 0, 3'd0, 5'd0, 64'd0, 64'd0);
        id_rs1_address = 0; id_rs2_address = 0; id_rs1_raw = 0; id_rs2_raw = 0;
        model_reset();

        vecs[0]  = '{3'b000, 3'd0, 64'hFFFF_FFFF_FFFF_FF81};
        vecs[1]  = '{3'b100, 3'd0, 64'h0000_0000_0000_0081};
        vecs[2]  = '{3'b000, 3'd1, 64'h0000_0000_0000_0022};
        vecs[3]  = '{3'b000, 3'd7, 64'hFFFF_FFFF_FFFF_FF88};
        vecs[4]  = '{3'b001, 3'd6, 64'hFFFF_FFFF_FFFF_8877};
        vecs[5]  = '{3'b001, 3'd7, 64'hFFFF_FFFF_FFFF_8877};
        vecs[6]  = '{3'b101, 3'd2, 64'h0000_0000_0000_4433};
        vecs[7]  = '{3'b001, 3'd0, 64'h0000_0000_0000_2281};
        vecs[8]  = '{3'b010, 3'd0, 64'h0000_0000_4433_2281};
        vecs[9]  = '{3'b010, 3'd4, 64'hFFFF_FFFF_8877_6655};
        vecs[10] = '{3'b110, 3'd4, 64'h0000_0000_8877_6655};
        vecs[11] = '{3'b110, 3'd6, 64'h0000_0000_8877_6655};
        vecs[12] = '{3'b111, 3'd3, 64'h8877_6655_4433_2281};

        #3;
        check("reset rf_reg_write", rf_reg_write, 0);
        check("reset rf_rd_address", rf_rd_address, 0);
        check("reset rf_write_data", rf_write_data, 0);
        check("reset wb_valid", wb_valid, 0);
        check("reset retired_count", retired_count, 0);
        #9 reset_n = 1;

        // ALU write-back to x5, then retire it behind a bubble
        drive(1, 1, 0, 3'd0, 5'd5, 64'h1234, 64'd0);
        step();
        check("alu we", rf_reg_write, 1);
        check("alu addr", rf_rd_address, 5);
        check("alu data", rf_write_data, 64'h1234);
        drive(0, 0, 0, 3'd0, 5'd0, 64'd0, 64'd0);
        step();
        check("alu count", retired_count, 1);
        check("bubble we", rf_reg_write, 0);

        // Write to x0 is suppressed but still retires
        drive(1, 1, 0, 3'd0, 5'd0, 64'h1234, 64'd0);
        step();
        check("x0 we", rf_reg_write, 0);
        drive(0, 0, 0, 3'd0, 5'd0, 64'd0, 64'd0);
        step();
        check("x0 count", retired_count, 2);

        for (int i = 0; i < 13; i++) begin
            drive(1, 1, 1, vecs[i].f3, 5'd3, 64'h1000 | 64'(vecs[i].off), LD_DATA);
            step();
            check($sformatf("load[%0d]", i), rf_write_data, vecs[i].exp);
        end

        // Stall for three cycles with garbage on the inputs, then stall+flush
        drive(1, 1, 0, 3'd0, 5'd5, 64'h1234, 64'd0);
        step();
        saved_cnt = m_cnt;
        stall = 1;
        drive(1, 1, 0, 3'd0, 5'd9, 64'hBAD, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall we", rf_reg_write, 1);
            check("stall addr", rf_rd_address, 5);
            check("stall data", rf_write_data, 64'h1234);
            check("stall count", retired_count, saved_cnt);
        end
        flush = 1;
        step();
        check("flush wb_valid", wb_valid, 0);
        check("flush count", retired_count, saved_cnt + 64'd1);
        flush = 0;
        stall = 0;

        // Asynchronous reset while a valid write is held
        drive(1, 1, 0, 3'd0, 5'd6, 64'h77, 64'd0);
        step();
        stall = 1;
        step();
        #3 reset_n = 0;
        #1;
        model_reset();
        check("async rst we", rf_reg_write, 0);
        check("async rst count", retired_count, 0);
        check("async rst wb_valid", wb_valid, 0);
        check("async rst data", rf_write_data, 0);
        #2 reset_n = 1;
        stall = 0;
        drive(1, 1, 0, 3'd0, 5'd8, 64'hABC, 64'd0);
        step();
        check("post rst we", rf_reg_write, 1);
        check("post rst addr", rf_rd_address, 8);
        check("post rst data", rf_write_data, 64'hABC);

`ifdef WB_BYPASS_EN
        drive(1, 1, 0, 3'd0, 5'd7, 64'hDEAD, 64'd0);
        id_rs1_address = 7; id_rs1_raw = 0;
        id_rs2_address = 0; id_rs2_raw = 64'h55;
        step();
        check("bypass rs1", id_rs1_data, 64'hDEAD);
        check("bypass rs2 raw", id_rs2_data, 64'h55);
        drive(1, 1, 0, 3'd0, 5'd0, 64'h99, 64'd0);
        step();
        check("bypass x0 rs2", id_rs2_data, 64'h55);
        check("bypass x0 rs1", id_rs1_data, 64'h0);
`endif

        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                  3'($urandom), 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            id_rs1_address = ($urandom_range(0, 1) == 1) ? mem_rd : 5'($urandom);
            id_rs2_address = ($urandom_range(0, 1) == 1) ? mem_rd : 5'($urandom);
            id_rs1_raw = {$urandom, $urandom};
            id_rs2_raw = {$urandom, $urandom};
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
